// File: rtl/cam_cmd_pkg.sv
// Shared command codes, FSM encoding, default values and sensor register addresses
// for the camera command controller.
package cam_cmd_pkg;

    localparam logic [3:0] CmdBriUp    = 4'h0;
    localparam logic [3:0] CmdBriDn    = 4'h1;
    localparam logic [3:0] CmdConUp    = 4'h2;
    localparam logic [3:0] CmdConDn    = 4'h3;
    localparam logic [3:0] CmdExpUp    = 4'h4;
    localparam logic [3:0] CmdExpDn    = 4'h5;
    localparam logic [3:0] CmdDefaults = 4'h6;
    localparam logic [3:0] CmdSelCam0  = 4'h8;
    localparam logic [3:0] CmdSelCam1  = 4'h9;
    localparam logic [3:0] CmdSelBoth  = 4'hA;

    localparam logic [7:0] BriDef = 8'h80;
    localparam logic [7:0] ConDef = 8'h20;
    localparam logic [7:0] ExpDef = 8'h30;

    localparam logic [15:0] BriAddr = 16'h5587;
    localparam logic [15:0] ConAddr = 16'h5586;
    localparam logic [15:0] ExpAddr = 16'h3A0F;

    typedef enum logic [1:0] {StIdle, StCalc, StReq, StNext} state_e;

    function automatic logic is_write_cmd(input logic [3:0] code);
        return code <= CmdDefaults;
    endfunction

endpackage

// File: rtl/cam_param_sat.sv
// 8-bit camera parameter register with saturating up/down steps and load-default.
module cam_param_sat
    import cam_cmd_pkg::*;
#(
    parameter int unsigned STEP = 16,
    parameter logic [7:0]  DEF  = 8'h80
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       up_i,
    input  logic       down_i,
    input  logic       load_def_i,
    output logic [7:0] value_o,
    output logic [7:0] value_nxt_o
);

    logic [7:0] value_q;
    logic [8:0] sum;
    logic [8:0] diff;

    // Bit 8 flags overflow on the add and borrow on the subtract.
    assign sum  = {1'b0, value_q} + 9'(STEP);
    assign diff = {1'b0, value_q} - 9'(STEP);

    always_comb begin
        value_nxt_o = value_q;
        if (load_def_i) begin
            value_nxt_o = DEF;
        end else if (up_i) begin
            value_nxt_o = sum[8] ? 8'hFF : sum[7:0];
        end else if (down_i) begin
            value_nxt_o = diff[8] ? 8'h00 : diff[7:0];
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            value_q <= DEF;
        end else begin
            value_q <= value_nxt_o;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/cam_cmd_ctrl.sv
// Camera command controller: turns UART command strobes into saturating parameter updates
// and SCCB register writes, with a one-entry pending slot and ack timeout.
module cam_cmd_ctrl
    import cam_cmd_pkg::*;
#(
    parameter int unsigned  STEP        = 16,
    parameter logic [7:0]   BRI_DEF     = BriDef,
    parameter logic [7:0]   CON_DEF     = ConDef,
    parameter logic [7:0]   EXP_DEF     = ExpDef,
    parameter logic [15:0]  BRI_ADDR    = BriAddr,
    parameter logic [15:0]  CON_ADDR    = ConAddr,
    parameter logic [15:0]  EXP_ADDR    = ExpAddr,
    parameter int unsigned  ACK_TIMEOUT = 50000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [3:0]  command_data,
    input  logic        act_flag,
    output logic        wr_req,
    output logic [1:0]  wr_cam_sel,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    input  logic        wr_done,
    output logic        busy,
    output logic        cmd_drop,
    output logic        err_timeout
);

    localparam int unsigned    CntW   = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(ACK_TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [3:0]      code_q, code_d;
    logic            pend_valid_q, pend_valid_d;
    logic [3:0]      pend_code_q, pend_code_d;
    logic [1:0]      sel_q, sel_d;
    logic [1:0]      idx_q, idx_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            drop_d;
    logic [15:0]     addr_d;
    logic [7:0]      data_d;
    logic [1:0]      cam_sel_d;

    logic is_wr, is_sel, more_writes;
    logic calc_en, next_en, timeout_hit;
    logic [7:0] bri_val, con_val, exp_val;
    logic [7:0] bri_nxt, con_nxt, exp_nxt;

    assign is_wr       = act_flag && is_write_cmd(command_data);
    assign is_sel      = act_flag && (command_data inside {CmdSelCam0, CmdSelCam1, CmdSelBoth});
    assign more_writes = (code_q == CmdDefaults) && (idx_q < 2'd2);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (pend_valid_q || is_wr) state_d = StCalc;
            StCalc: state_d = StReq;
            StReq: begin
                if (wr_done) begin
                    state_d = more_writes ? StNext : StIdle;
                end else if (cnt_q == CntMax) begin
                    state_d = StIdle;
                end
            end
            StNext: state_d = StReq;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy        = (state_q != StIdle);
        calc_en     = (state_q == StCalc);
        next_en     = (state_q == StNext);
        timeout_hit = (state_q == StReq) && !wr_done && (cnt_q == CntMax);
    end

    // A queued command beats a fresh strobe in IDLE; the fresh one refills the slot.
    always_comb begin
        code_d       = code_q;
        pend_valid_d = pend_valid_q;
        pend_code_d  = pend_code_q;
        drop_d       = 1'b0;
        if (state_q == StIdle) begin
            if (pend_valid_q) begin
                code_d       = pend_code_q;
                pend_valid_d = is_wr;
                if (is_wr) pend_code_d = command_data;
            end else if (is_wr) begin
                code_d = command_data;
            end
        end else if (is_wr) begin
            if (pend_valid_q) begin
                drop_d = 1'b1;
            end else begin
                pend_valid_d = 1'b1;
                pend_code_d  = command_data;
            end
        end
    end

    always_comb begin
        sel_d = sel_q;
        if (is_sel) begin
            case (command_data)
                CmdSelCam0: sel_d = 2'b01;
                CmdSelCam1: sel_d = 2'b10;
                default:    sel_d = 2'b11;
            endcase
        end
    end

    cam_param_sat #(.STEP(STEP), .DEF(BRI_DEF)) u_bri (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .up_i        (calc_en && (code_q == CmdBriUp)),
        .down_i      (calc_en && (code_q == CmdBriDn)),
        .load_def_i  (calc_en && (code_q == CmdDefaults)),
        .value_o     (bri_val),
        .value_nxt_o (bri_nxt)
    );

    cam_param_sat #(.STEP(STEP), .DEF(CON_DEF)) u_con (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .up_i        (calc_en && (code_q == CmdConUp)),
        .down_i      (calc_en && (code_q == CmdConDn)),
        .load_def_i  (calc_en && (code_q == CmdDefaults)),
        .value_o     (con_val),
        .value_nxt_o (con_nxt)
    );

    cam_param_sat #(.STEP(STEP), .DEF(EXP_DEF)) u_exp (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .up_i        (calc_en && (code_q == CmdExpUp)),
        .down_i      (calc_en && (code_q == CmdExpDn)),
        .load_def_i  (calc_en && (code_q == CmdDefaults)),
        .value_o     (exp_val),
        .value_nxt_o (exp_nxt)
    );

    // CALC writes the freshly updated value; NEXT walks the restore sequence CON then EXP.
    always_comb begin
        addr_d    = wr_addr;
        data_d    = wr_data;
        cam_sel_d = wr_cam_sel;
        idx_d     = idx_q;
        cnt_d     = ((state_q == StReq) && (state_d == StReq)) ? cnt_q + CntW'(1) : '0;
        if (calc_en) begin
            idx_d     = 2'd0;
            cam_sel_d = sel_q;
            case (code_q)
                CmdConUp, CmdConDn: begin addr_d = CON_ADDR; data_d = con_nxt; end
                CmdExpUp, CmdExpDn: begin addr_d = EXP_ADDR; data_d = exp_nxt; end
                default:            begin addr_d = BRI_ADDR; data_d = bri_nxt; end
            endcase
        end else if (next_en) begin
            idx_d     = idx_q + 2'd1;
            cam_sel_d = sel_q;
            case (idx_q)
                2'd0:    begin addr_d = CON_ADDR; data_d = con_val; end
                2'd1:    begin addr_d = EXP_ADDR; data_d = exp_val; end
                default: begin addr_d = BRI_ADDR; data_d = bri_val; end
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            code_q       <= '0;
            pend_valid_q <= 1'b0;
            pend_code_q  <= '0;
            sel_q        <= 2'b11;
            idx_q        <= '0;
            cnt_q        <= '0;
            wr_req       <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            wr_cam_sel   <= 2'b11;
            cmd_drop     <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            code_q       <= code_d;
            pend_valid_q <= pend_valid_d;
            pend_code_q  <= pend_code_d;
            sel_q        <= sel_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            wr_req       <= (state_d == StReq);
            wr_addr      <= addr_d;
            wr_data      <= data_d;
            wr_cam_sel   <= cam_sel_d;
            cmd_drop     <= drop_d;
            err_timeout  <= timeout_hit;
        end
    end

endmodule

// File: tb/tb_cam_cmd_ctrl.sv
// Directed self-checking bench for cam_cmd_ctrl with a shortened ack timeout.
module tb_cam_cmd_ctrl;

    logic        sys_clk      = 1'b0;
    logic        sys_rst_n    = 1'b0;
    logic [3:0]  command_data = 4'h0;
    logic        act_flag     = 1'b0;
    logic        wr_done      = 1'b0;
    logic        wr_req;
    logic [1:0]  wr_cam_sel;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        busy;
    logic        cmd_drop;
    logic        err_timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    int drop_cnt = 0;
    int err_cnt  = 0;
    logic req_prev = 1'b0;

    logic [7:0] exp_tab [14] = '{8'h40, 8'h50, 8'h60, 8'h70, 8'h80, 8'h90, 8'hA0,
                                 8'hB0, 8'hC0, 8'hD0, 8'hE0, 8'hF0, 8'hFF, 8'hFF};

    cam_cmd_ctrl #(.ACK_TIMEOUT(100)) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .command_data (command_data),
        .act_flag     (act_flag),
        .wr_req       (wr_req),
        .wr_cam_sel   (wr_cam_sel),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_done      (wr_done),
        .busy         (busy),
        .cmd_drop     (cmd_drop),
        .err_timeout  (err_timeout)
    );

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (wr_req && !req_prev) wr_cnt <= wr_cnt + 1;
        if (cmd_drop) drop_cnt <= drop_cnt + 1;
        if (err_timeout) err_cnt <= err_cnt + 1;
        req_prev <= wr_req;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_cmd(input logic [3:0] code);
        command_data = code;
        act_flag     = 1'b1;
        tick();
        act_flag     = 1'b0;
    endtask

    task automatic wait_write(input string tag, input logic [15:0] addr, input logic [7:0] data,
                              input logic [1:0] sel);
        int n = 0;
        while (!wr_req && n < 30) begin
            tick();
            n++;
        end
        check({tag, "_req"}, 32'(wr_req), 32'd1);
        check({tag, "_addr"}, 32'(wr_addr), 32'(addr));
        check({tag, "_data"}, 32'(wr_data), 32'(data));
        check({tag, "_sel"}, 32'(wr_cam_sel), 32'(sel));
    endtask

    task automatic ack(input string tag);
        ticks(3);
        check({tag, "_hold"}, 32'(wr_req), 32'd1);
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
        check({tag, "_fall"}, 32'(wr_req), 32'd0);
    endtask

    initial begin
        int w0;
        int d0;
        int n;

        // Reset state
        ticks(3);
        check("rst_req", 32'(wr_req), 32'd0);
        check("rst_sel", 32'(wr_cam_sel), 32'd3);
        check("rst_addr", 32'(wr_addr), 32'd0);
        check("rst_data", 32'(wr_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_drop", 32'(cmd_drop), 32'd0);
        check("rst_err", 32'(err_timeout), 32'd0);
        sys_rst_n = 1'b1;
        ticks(2);

        // Brightness up: CALC after first edge, wr_req after second
        do_cmd(4'h0);
        check("t1_calc_req", 32'(wr_req), 32'd0);
        check("t1_calc_busy", 32'(busy), 32'd1);
        tick();
        check("t1_req", 32'(wr_req), 32'd1);
        check("t1_addr", 32'(wr_addr), 32'h5587);
        check("t1_data", 32'(wr_data), 32'h90);
        check("t1_sel", 32'(wr_cam_sel), 32'd3);
        ticks(9);
        check("t1_addr_hold", 32'(wr_addr), 32'h5587);
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
        check("t1_done_req", 32'(wr_req), 32'd0);
        check("t1_done_busy", 32'(busy), 32'd0);

        // Select cam1 then contrast down: exactly one write
        w0 = wr_cnt;
        do_cmd(4'h9);
        do_cmd(4'h3);
        wait_write("t2", 16'h5586, 8'h10, 2'b10);
        ack("t2");
        ticks(10);
        check("t2_one_write", 32'(wr_cnt - w0), 32'd1);

        // Exposure up to saturation, then restore defaults
        do_cmd(4'hA);
        for (int i = 0; i < 14; i++) begin
            do_cmd(4'h4);
            wait_write("t3_exp", 16'h3A0F, exp_tab[i], 2'b11);
            ack("t3_exp");
        end
        w0 = wr_cnt;
        do_cmd(4'h6);
        wait_write("t3_def_bri", 16'h5587, 8'h80, 2'b11);
        ack("t3_def_bri");
        wait_write("t3_def_con", 16'h5586, 8'h20, 2'b11);
        ack("t3_def_con");
        wait_write("t3_def_exp", 16'h3A0F, 8'h30, 2'b11);
        ack("t3_def_exp");
        ticks(10);
        check("t3_def_count", 32'(wr_cnt - w0), 32'd3);

        // Pending slot: 0x1 queued, 0x2 dropped
        w0 = wr_cnt;
        d0 = drop_cnt;
        do_cmd(4'h4);
        wait_write("t4_exp", 16'h3A0F, 8'h40, 2'b11);
        do_cmd(4'h1);
        do_cmd(4'h2);
        ticks(2);
        check("t4_drop_once", 32'(drop_cnt - d0), 32'd1);
        check("t4_data_stable", 32'(wr_data), 32'h40);
        ack("t4_exp");
        wait_write("t4_pend", 16'h5587, 8'h70, 2'b11);
        ack("t4_pend");
        ticks(15);
        check("t4_write_count", 32'(wr_cnt - w0), 32'd2);
        check("t4_drop_total", 32'(drop_cnt - d0), 32'd1);

        // Ack timeout after 100 cycles
        do_cmd(4'h0);
        wait_write("t5", 16'h5587, 8'h80, 2'b11);
        n = 0;
        while (!err_timeout && n < 200) begin
            tick();
            n++;
        end
        check("t5_to_cycles", 32'(n), 32'd100);
        check("t5_to_req", 32'(wr_req), 32'd0);
        check("t5_to_busy", 32'(busy), 32'd0);
        tick();
        check("t5_to_pulse", 32'(err_timeout), 32'd0);
        check("t5_to_count", 32'(err_cnt), 32'd1);

        // Unused codes do nothing
        w0 = wr_cnt;
        d0 = drop_cnt;
        do_cmd(4'h7);
        check("t5_c7_busy", 32'(busy), 32'd0);
        do_cmd(4'hF);
        check("t5_cf_busy", 32'(busy), 32'd0);
        ticks(5);
        check("t5_ign_writes", 32'(wr_cnt - w0), 32'd0);
        check("t5_ign_drops", 32'(drop_cnt - d0), 32'd0);

        // Reset during REQ
        do_cmd(4'h2);
        wait_write("t6", 16'h5586, 8'h30, 2'b11);
        ticks(2);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("t6_rst_req", 32'(wr_req), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_addr", 32'(wr_addr), 32'd0);
        check("t6_rst_sel", 32'(wr_cam_sel), 32'd3);
        ticks(2);
        sys_rst_n = 1'b1;
        w0 = wr_cnt;
        ticks(20);
        check("t6_no_write", 32'(wr_cnt - w0), 32'd0);
        do_cmd(4'h0);
        wait_write("t6_bri", 16'h5587, 8'h90, 2'b11);
        ack("t6_bri");
        do_cmd(4'h2);
        wait_write("t6_con", 16'h5586, 8'h30, 2'b11);
        ack("t6_con");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
